// File: rtl/dense_layer_if.sv
// rtl/dense_layer_if.sv - start/result handshake and weight/bias memory ports of dense_layer
//
// Purpose: bundles everything except clk/rst that passes between a dense_layer
// and its controller and memories.
// Signals:
//   start    controller -> engine   level request, taken only when idle
//   in_vec   controller -> engine   NB_INPUTS packed Q16.16 words, element j at [j*FIXED +: FIXED]
//   out_vec  engine -> controller   NB_NEURONS packed Q16.16 results, same packing
//   valid    engine -> controller   result ready (level)
//   w_addr   engine -> weight mem   read address, data returns one cycle later on w_data
//   b_addr   engine -> bias mem     read address, data returns one cycle later on b_data
// Modports: master = controller/memory side, slave = engine side.
interface dense_layer_if #(
  parameter int FIXED      = 32,
  parameter int NB_INPUTS  = 42,
  parameter int NB_NEURONS = 24,
  parameter int AW         = 16
);
  logic                         start;
  logic [NB_INPUTS*FIXED-1:0]   in_vec;
  logic [AW-1:0]                w_addr;
  logic [FIXED-1:0]             w_data;
  logic [7:0]                   b_addr;
  logic [FIXED-1:0]             b_data;
  logic [NB_NEURONS*FIXED-1:0]  out_vec;
  logic                         valid;

  modport master (
    output start, in_vec, w_data, b_data,
    input  w_addr, b_addr, out_vec, valid
  );

  modport slave (
    input  start, in_vec, w_data, b_data,
    output w_addr, b_addr, out_vec, valid
  );
endinterface

// File: rtl/dense_layer.sv
// rtl/dense_layer.sv - fixed-point fully connected layer, one multiply-accumulate per cycle
//
// Purpose: out[i] = act(scale * (bias[i] + sum_j in[j]*W[j][i])) in signed Q16.16,
// weights at j*NB_NEURONS+i and biases at i in external one-cycle-latency memories.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  dense_layer_if.slave: start/in_vec in, out_vec/valid out,
//        w_addr/b_addr out with w_data/b_data returned one cycle later
// Per neuron: one BIAS cycle, NB_INPUTS MAC cycles, one ACT cycle.
module dense_layer #(
  parameter int          FIXED         = 32,
  parameter int          NB_INPUTS     = 42,
  parameter int          NB_NEURONS    = 24,
  parameter int          ACT           = 0,
  parameter logic [31:0] WEIGHTS_SCALE = 32'h0000_0100,
  parameter int          AW            = 16
) (
  input logic          clk,
  input logic          rst,
  dense_layer_if.slave bus
);

  // Guard bits so that summing NB_INPUTS full-scale products cannot wrap.
  localparam int ACC_W = 2 * FIXED + 8;
  localparam int JW    = (NB_INPUTS > 1) ? $clog2(NB_INPUTS) : 1;
  localparam int NW    = (NB_NEURONS > 1) ? $clog2(NB_NEURONS) : 1;

  localparam logic [AW-1:0]               NB_STEP  = AW'(NB_NEURONS);
  localparam logic [FIXED-1:0]            SCALE    = FIXED'(WEIGHTS_SCALE);
  localparam logic signed [FIXED-1:0]     ONE      = FIXED'(65536);
  localparam logic signed [FIXED-1:0]     NEG_ONE  = FIXED'(-65536);
  localparam logic signed [FIXED+1:0]     SIG_HALF = (FIXED + 2)'(32768);
  localparam logic signed [FIXED+1:0]     SIG_ONE  = (FIXED + 2)'(65536);

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_ACT, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [NW-1:0]                nidx_q, nidx_d;
  logic [JW-1:0]                jidx_q, jidx_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [AW-1:0]                w_addr_q, w_addr_d;
  logic [7:0]                   b_addr_q, b_addr_d;
  logic [NB_NEURONS*FIXED-1:0]  out_vec_q, out_vec_d;
  logic                         valid_q, valid_d;

  logic signed [FIXED-1:0]      in_j;
  logic signed [FIXED-1:0]      w_s;
  logic signed [2*FIXED-1:0]    prod;
  logic signed [ACC_W-1:0]      bias_acc;
  logic signed [ACC_W-1:0]      acc_base;
  logic signed [ACC_W-1:0]      acc_next;
  logic [FIXED-1:0]             sum_w;
  logic signed [2*FIXED-1:0]    scaled;
  logic [FIXED-1:0]             s_w;
  logic signed [FIXED+1:0]      sig_t;
  logic [FIXED-1:0]             act_w;

  // Clip to the FIXED-bit signed range: in range iff all bits from the
  // FIXED-bit sign position upward agree.
  function automatic logic [FIXED-1:0] sat_fixed(input logic signed [ACC_W-1:0] v);
    logic [FIXED-1:0] r;
    if ((&v[ACC_W-1:FIXED-1]) || (~|v[ACC_W-1:FIXED-1])) begin
      r = v[FIXED-1:0];
    end else if (v[ACC_W-1]) begin
      r = {1'b1, {(FIXED-1){1'b0}}};
    end else begin
      r = {1'b0, {(FIXED-1){1'b1}}};
    end
    return r;
  endfunction

  // Datapath: MAC term, post-sum scaling and activation.
  always_comb begin
    in_j     = $signed(bus.in_vec[jidx_q*FIXED +: FIXED]);
    w_s      = $signed(bus.w_data);
    prod     = $signed({{FIXED{in_j[FIXED-1]}}, in_j}) * $signed({{FIXED{w_s[FIXED-1]}}, w_s});
    // Bias is Q16.16; the accumulator is Q32.32.
    bias_acc = $signed({{(ACC_W-FIXED){bus.b_data[FIXED-1]}}, bus.b_data}) <<< 16;
    // j==0 restarts the sum from the bias that just arrived from memory.
    acc_base = (jidx_q == '0) ? bias_acc : acc_q;
    acc_next = acc_base + $signed({{(ACC_W-2*FIXED){prod[2*FIXED-1]}}, prod});

    sum_w    = sat_fixed(acc_q >>> 16);
    scaled   = $signed({{FIXED{sum_w[FIXED-1]}}, sum_w}) * $signed({{FIXED{SCALE[FIXED-1]}}, SCALE});
    s_w      = sat_fixed($signed({{(ACC_W-2*FIXED){scaled[2*FIXED-1]}}, scaled}) >>> 16);
    sig_t    = ($signed({{2{s_w[FIXED-1]}}, s_w}) >>> 2) + SIG_HALF;

    act_w = s_w;
    case (ACT)
      0: begin
        if ($signed(s_w) > ONE) begin
          act_w = ONE;
        end else if ($signed(s_w) < NEG_ONE) begin
          act_w = NEG_ONE;
        end
      end
      1: begin
        if (sig_t < 0) begin
          act_w = '0;
        end else if (sig_t > SIG_ONE) begin
          act_w = ONE;
        end else begin
          act_w = sig_t[FIXED-1:0];
        end
      end
      2: begin
        if (s_w[FIXED-1]) begin
          act_w = '0;
        end
      end
      default: act_w = s_w;
    endcase
  end

  // Control: w_addr always points one weight ahead of the MAC that consumes it.
  always_comb begin
    state_d   = state_q;
    nidx_d    = nidx_q;
    jidx_d    = jidx_q;
    acc_d     = acc_q;
    w_addr_d  = w_addr_q;
    b_addr_d  = b_addr_q;
    out_vec_d = out_vec_q;
    valid_d   = valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_BIAS;
          nidx_d   = '0;
          w_addr_d = '0;
          b_addr_d = '0;
          valid_d  = 1'b0;
        end
      end
      S_BIAS: begin
        state_d = S_MAC;
        jidx_d  = '0;
        if (NB_INPUTS > 1) begin
          w_addr_d = w_addr_q + NB_STEP;
        end
      end
      S_MAC: begin
        acc_d = acc_next;
        if (jidx_q == JW'(NB_INPUTS - 1)) begin
          state_d = S_ACT;
        end else begin
          jidx_d = jidx_q + 1'b1;
        end
        // Stop advancing once the last weight of this neuron is addressed.
        if (32'(jidx_q) + 2 < NB_INPUTS) begin
          w_addr_d = w_addr_q + NB_STEP;
        end
      end
      S_ACT: begin
        out_vec_d[nidx_q*FIXED +: FIXED] = act_w;
        if (nidx_q == NW'(NB_NEURONS - 1)) begin
          state_d = S_DONE;
        end else begin
          nidx_d   = nidx_q + 1'b1;
          w_addr_d = AW'(nidx_q) + 1'b1;
          b_addr_d = 8'(nidx_q) + 1'b1;
          state_d  = S_BIAS;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        if (!bus.start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      nidx_q    <= '0;
      jidx_q    <= '0;
      acc_q     <= '0;
      w_addr_q  <= '0;
      b_addr_q  <= '0;
      out_vec_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      nidx_q    <= nidx_d;
      jidx_q    <= jidx_d;
      acc_q     <= acc_d;
      w_addr_q  <= w_addr_d;
      b_addr_q  <= b_addr_d;
      out_vec_q <= out_vec_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.w_addr  = w_addr_q;
  assign bus.b_addr  = b_addr_q;
  assign bus.out_vec = out_vec_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_dense_layer.sv
// tb/tb_dense_layer.sv - self-checking bench for dense_layer
//
// Four 2->3 engines (one per activation, scale 1.0) and one 2->1 linear engine
// with the default 1/256 scale share start/in_vec; each has its own memory model.
module tb_dense_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [63:0] in_vec;

  logic [31:0] wmem [8];
  logic [31:0] bmem [4];
  logic [31:0] wmem1 [2];
  logic [31:0] bmem1;

  logic [95:0] outs  [4];
  logic        vals  [4];
  logic [15:0] waddr [4];
  logic [7:0]  baddr [4];
  logic [31:0] out1;
  logic        val1;
  logic [15:0] waddr1;
  logic [7:0]  baddr1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_out [5][3];

  for (genvar a = 0; a < 4; a++) begin : g
    dense_layer_if #(.FIXED(32), .NB_INPUTS(2), .NB_NEURONS(3), .AW(16)) bus ();
    assign bus.start  = start;
    assign bus.in_vec = in_vec;
    always @(posedge clk) begin
      bus.w_data <= (bus.w_addr < 16'd6) ? wmem[bus.w_addr[2:0]] : 32'h0;
      bus.b_data <= (bus.b_addr < 8'd3) ? bmem[bus.b_addr[1:0]] : 32'h0;
    end
    dense_layer #(
      .FIXED(32), .NB_INPUTS(2), .NB_NEURONS(3), .ACT(a),
      .WEIGHTS_SCALE(32'h0001_0000), .AW(16)
    ) u_dut (
      .clk(clk),
      .rst(rst_n),
      .bus(bus)
    );
    assign outs[a]  = bus.out_vec;
    assign vals[a]  = bus.valid;
    assign waddr[a] = bus.w_addr;
    assign baddr[a] = bus.b_addr;
  end

  dense_layer_if #(.FIXED(32), .NB_INPUTS(2), .NB_NEURONS(1), .AW(16)) bus1 ();
  assign bus1.start  = start;
  assign bus1.in_vec = in_vec;
  always @(posedge clk) begin
    bus1.w_data <= (bus1.w_addr < 16'd2) ? wmem1[bus1.w_addr[0]] : 32'h0;
    bus1.b_data <= (bus1.b_addr == 8'd0) ? bmem1 : 32'h0;
  end
  dense_layer #(
    .FIXED(32), .NB_INPUTS(2), .NB_NEURONS(1), .ACT(3), .AW(16)
  ) u_dut1 (
    .clk(clk),
    .rst(rst_n),
    .bus(bus1)
  );
  assign out1   = bus1.out_vec;
  assign val1   = bus1.valid;
  assign waddr1 = bus1.w_addr;
  assign baddr1 = bus1.b_addr;

  // ---------------- reference model ----------------
  function automatic logic signed [127:0] sx(input logic [31:0] v);
    return {{96{v[31]}}, v};
  endfunction

  function automatic logic signed [127:0] sat(input logic signed [127:0] v);
    if (v > 128'sh7FFF_FFFF) return 128'sh7FFF_FFFF;
    if (v < -128'sh8000_0000) return -128'sh8000_0000;
    return v;
  endfunction

  function automatic logic [31:0] ref_neuron(input int act, input logic [31:0] scale,
                                             input logic [31:0] x0, input logic [31:0] x1,
                                             input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] b);
    logic signed [127:0] acc, sum, s, r;
    acc = sx(b) * 65536 + sx(x0) * sx(w0) + sx(x1) * sx(w1);
    sum = sat(acc >>> 16);
    s   = sat((sum * sx(scale)) >>> 16);
    case (act)
      0: r = (s > 65536) ? 65536 : ((s < -65536) ? -65536 : s);
      1: begin
        r = 32768 + (s >>> 2);
        if (r < 0) r = 0;
        if (r > 65536) r = 65536;
      end
      2: r = (s < 0) ? 0 : s;
      default: r = s;
    endcase
    return r[31:0];
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  function automatic bit all_valid();
    return vals[0] && vals[1] && vals[2] && vals[3] && val1;
  endfunction

  task automatic compute_expected();
    for (int a = 0; a < 4; a++)
      for (int k = 0; k < 3; k++)
        exp_out[a][k] = ref_neuron(a, 32'h0001_0000, in_vec[31:0], in_vec[63:32],
                                   wmem[k], wmem[3+k], bmem[k]);
    exp_out[4][0] = ref_neuron(3, 32'h0000_0100, in_vec[31:0], in_vec[63:32],
                               wmem1[0], wmem1[1], bmem1);
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 4; a++)
      for (int k = 0; k < 3; k++)
        chk($sformatf("%s act%0d n%0d", tag, a, k), outs[a][k*32 +: 32], exp_out[a][k]);
    chk($sformatf("%s dflt n0", tag), out1, exp_out[4][0]);
  endtask

  task automatic start_and_wait();
    int cycles;
    start  = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!all_valid() && cycles < 200);
    n_checks++;
    if (!all_valid()) begin
      n_fail++;
      $display("FAIL run timeout: valid not seen within %0d cycles", cycles);
    end
  endtask

  task automatic end_run();
    start = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_val();
    int sh;
    sh = $urandom_range(2, 16);
    return 32'($signed($urandom) >>> sh);
  endfunction

  task automatic randomize_all();
    in_vec = {rnd_val(), rnd_val()};
    for (int i = 0; i < 8; i++) wmem[i] = (i < 6) ? rnd_val() : 32'h0;
    for (int i = 0; i < 4; i++) bmem[i] = (i < 3) ? rnd_val() : 32'h0;
    wmem1[0] = rnd_val();
    wmem1[1] = rnd_val();
    bmem1    = rnd_val();
  endtask

  typedef struct {
    int          inst;
    logic [31:0] x0, x1, w0, w1, b, want;
  } vec_t;

  vec_t        tbl [15];
  logic [15:0] wlog  [14];
  logic [7:0]  blog  [14];
  logic        vlog  [14];
  logic        v1log [14];
  logic [31:0] keep_el;
  int          hold_bad;

  initial begin
    // inst 0..3 = 2->3 engine with that ACT at scale 1.0; inst 4 = 2->1 linear, scale 1/256
    tbl[0]  = '{3, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_4000, 32'h0001_4000};
    tbl[1]  = '{0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0003_0000, 32'h0001_0000};
    tbl[2]  = '{0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFD_0000, 32'hFFFF_0000};
    tbl[3]  = '{0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_8000, 32'h0000_8000};
    tbl[4]  = '{0, 32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0001_0000};
    tbl[5]  = '{1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_8000};
    tbl[6]  = '{1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0000_C000};
    tbl[7]  = '{1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0004_0000, 32'h0001_0000};
    tbl[8]  = '{1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFC_0000, 32'h0};
    tbl[9]  = '{1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_7FFF};
    tbl[10] = '{2, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000, 32'h0};
    tbl[11] = '{2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_8000, 32'h0001_8000};
    tbl[12] = '{4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0100_0000, 32'h0001_0000};
    tbl[13] = '{4, 32'h7FFF_0000, 32'h0, 32'h7FFF_0000, 32'h0, 32'h0, 32'h007F_FFFF};
    tbl[14] = '{4, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rst_n  = 1'b0;
    start  = 1'b0;
    in_vec = '0;
    for (int i = 0; i < 8; i++) wmem[i] = '0;
    for (int i = 0; i < 4; i++) bmem[i] = '0;
    wmem1[0] = '0;
    wmem1[1] = '0;
    bmem1    = '0;
    repeat (3) @(negedge clk);

    // Reset state
    for (int a = 0; a < 4; a++) begin
      chk($sformatf("reset valid act%0d", a), 32'(vals[a]), 32'h0);
      chk($sformatf("reset out act%0d", a), outs[a][31:0] | outs[a][63:32] | outs[a][95:64], 32'h0);
      chk($sformatf("reset w_addr act%0d", a), 32'(waddr[a]), 32'h0);
      chk($sformatf("reset b_addr act%0d", a), 32'(baddr[a]), 32'h0);
    end
    chk("reset valid dflt", 32'(val1), 32'h0);
    chk("reset out dflt", out1, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < 8; i++) wmem[i] = '0;
      for (int i = 0; i < 4; i++) bmem[i] = '0;
      wmem[0]  = tbl[t].w0;
      wmem[3]  = tbl[t].w1;
      bmem[0]  = tbl[t].b;
      wmem1[0] = tbl[t].w0;
      wmem1[1] = tbl[t].w1;
      bmem1    = tbl[t].b;
      in_vec   = {tbl[t].x1, tbl[t].x0};
      start_and_wait();
      end_run();
      chk($sformatf("table[%0d]", t), (tbl[t].inst == 4) ? out1 : outs[tbl[t].inst][31:0], tbl[t].want);
    end

    // Random vectors against the model
    for (int r = 0; r < 12; r++) begin
      randomize_all();
      compute_expected();
      start_and_wait();
      end_run();
      check_all($sformatf("rand%0d", r));
    end

    // start held high: results stay, valid stays, no restart
    randomize_all();
    compute_expected();
    start_and_wait();
    hold_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!all_valid() || baddr[3] != 8'd2) hold_bad++;
    end
    chk("hold start high", 32'(hold_bad), 32'h0);
    check_all("hold");

    // Drop and re-raise start: valid clears, timing and address order
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      wlog[c]  = waddr[3];
      blog[c]  = baddr[3];
      vlog[c]  = vals[3];
      v1log[c] = val1;
      if (c == 1) keep_el = outs[3][95:64];
    end
    end_run();
    chk("valid clears on restart", 32'(vlog[0]), 32'h0);
    chk("2->3 valid before 13 clocks", 32'(vlog[12]), 32'h0);
    chk("2->3 valid at 13 clocks", 32'(vlog[13]), 32'h1);
    chk("2->1 valid before 5 clocks", 32'(v1log[4]), 32'h0);
    chk("2->1 valid at 5 clocks", 32'(v1log[5]), 32'h1);
    chk("old element kept mid-run", keep_el, exp_out[3][2]);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b_addr n%0d", k), 32'(blog[k*4]), 32'(k));
      for (int j = 0; j < 2; j++)
        chk($sformatf("w_addr n%0d j%0d", k, j), 32'(wlog[k*4+j]), 32'(j*3 + k));
    end
    check_all("restart");

    // Reset during MAC
    randomize_all();
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) begin
      chk($sformatf("midreset valid act%0d", a), 32'(vals[a]), 32'h0);
      chk($sformatf("midreset out act%0d", a), outs[a][31:0] | outs[a][63:32] | outs[a][95:64], 32'h0);
      chk($sformatf("midreset w_addr act%0d", a), 32'(waddr[a]), 32'h0);
      chk($sformatf("midreset b_addr act%0d", a), 32'(baddr[a]), 32'h0);
    end
    chk("midreset valid dflt", 32'(val1), 32'h0);
    chk("midreset out dflt", out1, 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle after reset valid", 32'(vals[3]), 32'h0);
    chk("idle after reset b_addr", 32'(baddr[3]), 32'h0);
    compute_expected();
    start_and_wait();
    end_run();
    check_all("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_layer.md
# dense_layer

Fully connected (dense) layer engine for the fixed-point RNN denoiser. It computes `out[i] = act(scale * (bias[i] + Σ_j in[j]*W[j][i]))` for every neuron using one multiply-accumulate per cycle. Weights and biases are read from external synchronous memories. The top level instantiates it three times:
- input dense: 42→24, tanh
- VAD output: 24→1, sigmoid
- denoise output: 96→22, sigmoid

## Interface
Parameters:
- `FIXED`, 32: word width, signed Q16.16.
- `NB_INPUTS`, 42: input vector length.
- `NB_NEURONS`, 24: output vector length.
- `ACT`, 0: activation select (0 = hard tanh, 1 = hard sigmoid, 2 = ReLU, 3 = linear).
- `WEIGHTS_SCALE`, 32'h0000_0100: Q16.16 post-sum scale (1/256).
- `AW`, 16: weight address width.

Ports:
- `clk` in 1: clock. Rising edge only.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level request. Accepted only in IDLE.
- `in_vec` in NB_INPUTS*FIXED: input vector. Element j occupies bits [(j+1)*FIXED-1 : j*FIXED]. Must be held stable while busy.
- `w_addr` out AW: weight read address.
- `w_data` in FIXED: weight word. Returned 1 cycle after `w_addr`.
- `b_addr` out 8: bias read address.
- `b_data` in FIXED: bias word. Returned 1 cycle after `b_addr`.
- `out_vec` out NB_NEURONS*FIXED: result vector, same element packing as `in_vec`.
- `valid` out 1: result ready (level).

## Operation
- Memory layout:
  - Weight for input j, neuron i is at `w_addr = j*NB_NEURONS + i`.
  - Bias for neuron i is at `b_addr = i`.
- States: IDLE → BIAS → MAC → ACT → (next neuron: BIAS | last: DONE) → IDLE.
- IDLE:
  - If `start`=1, clear neuron index i=0 and go to BIAS.
  - `valid` stays as left by DONE; it is 0 after reset.
- BIAS:
  - Issue `b_addr=i` and `w_addr=i` (j=0).
  - `valid` goes 0.
- MAC: NB_INPUTS cycles.
  - The first MAC cycle loads `acc = sext(b_data)<<16`.
  - Each cycle adds one product `in[j]*w_data` (64-bit signed, Q32.32).
  - `w_addr` advances by NB_NEURONS each cycle.
- ACT: one cycle, all combinational.
  - `sum = sat32(acc >>> 16)`.
  - `s = sat32((sum*WEIGHTS_SCALE) >>> 16)`.
  - Apply ACT:
    - hard tanh: clamp to [0xFFFF0000, 0x00010000].
    - hard sigmoid: clamp(0x8000 + (s>>>2), 0, 0x10000).
    - ReLU: max(s, 0).
    - linear: s.
  - Write the result to `out_vec` element i, then i++.
- DONE:
  - Assert `valid`.
  - Hold `valid` until `start` is 0, then return to IDLE with `valid` still 1.
  - `valid` clears on the next accepted start.
- Saturation (`sat32`): clip to 0x7FFFFFFF / 0x80000000.
- Arithmetic shifts floor toward −∞; no rounding.
- `start` while not in IDLE is ignored.
- Reset (any time, including mid-computation):
  - state IDLE;
  - `out_vec`, `valid`, `w_addr`, `b_addr` = 0;
  - the accumulator is cleared;
  - the aborted result is discarded.
- `out_vec` elements not yet recomputed keep their previous values during a run.

## Timing
- Per neuron: 1 BIAS cycle + NB_INPUTS MAC cycles + 1 ACT cycle.
- `valid` rises exactly NB_NEURONS*(NB_INPUTS+2)+1 clocks after the edge that samples `start` in IDLE.
- Examples:
  - 2→1 layer: 5 clocks.
  - 42→24 layer: 1057 clocks.
- `out_vec` element i is final at the ACT edge of neuron i. All elements are final when `valid` rises.
- With `start` held high: DONE waits, so there is no automatic restart until `start` goes low and high again.

## Test plan
- **Linear dot product.** Set ACT=3, WEIGHTS_SCALE=0x10000, 2→1. Inputs in=[0x10000, 0x20000], weights W=[0x8000, 0x4000], bias 0x4000. Expect `out_vec`=0x00014000 (1.25) and `valid` 5 clocks after start.
- **Hard tanh.** Set ACT=0, scale 1.0. Biases: sum 3.0 → 0x00010000; sum −3.0 → 0xFFFF0000; sum 0.5 → 0x00008000.
- **Hard sigmoid.** Set ACT=1. Sum 0 → 0x00008000; sum 1.0 → 0x0000C000; sum 4.0 → 0x00010000; sum −4.0 → 0.
- **Default scale.** Sum 256.0 (0x01000000), linear → 0x00010000. Overflowing accumulator (in=0x7FFF0000 × w=0x7FFF0000) → pre-scale sum saturates to 0x7FFFFFFF.
- **Address order.** 2→3 layer:
  - `w_addr` sequence 0,3, 1,4, 2,5;
  - `b_addr` sequence 0,1,2.
- **Handshake and reset.**
  - Hold `start` high: `valid` stays 1 and no second run starts.
  - Drop `start`, re-raise it: `valid` falls the next cycle.
  - Pull `rst` low mid-MAC: `valid`=0, `out_vec`=0, and the block returns to IDLE.
